proxy_shift_scheduler: RTL

- Controller for the weight-proxy row registers in the BISR systolic array.
- Drives the per-row shift_en lines and the global stall line of the delay-register chain.
- Reconfigures the shift mask from a BIST fault map through a safe hold/load/settle sequence.
- Throttles upstream feed while reconfiguring, so no in-flight word is corrupted by a mask change.

---
 rtl/proxy_shift_scheduler_if.sv | 25 ++
 rtl/proxy_shift_scheduler.sv | 116 +++++++++++
 2 files changed

// File: rtl/proxy_shift_scheduler_if.sv
// Handshake and row-control bundle between the reconfiguration requester/feed and the proxy shift scheduler.
interface proxy_shift_scheduler_if #(
  parameter int NUM_ROWS = 4
);
  logic [NUM_ROWS-1:0] fault_map;
  logic                cfg_req;
  logic                cfg_ack;
  logic                cfg_err;
  logic                feed_valid;
  logic                feed_ready;
  logic                stall;
  logic [NUM_ROWS-1:0] shift_en;
  logic                busy;
  logic [1:0]          state;

  modport master (
    output fault_map, cfg_req, feed_valid,
    input  cfg_ack, cfg_err, feed_ready, stall, shift_en, busy, state
  );

  modport slave (
    input  fault_map, cfg_req, feed_valid,
    output cfg_ack, cfg_err, feed_ready, stall, shift_en, busy, state
  );
endinterface

// File: rtl/proxy_shift_scheduler.sv
// Proxy row shift-enable scheduler: applies a BIST fault map via a hold/load/settle sequence.
// Optional PROXY_SHIFT_STATS_EN adds stall_cycles and reconfig_count statistics outputs.
//
// state  | meaning
// RUN    | normal streaming, accepts cfg_req
// HOLD   | feed throttled, chain stalled before the mask change
// LOAD   | chain stalled, new shift_en mask applied (or rejected)
// SETTLE | chain unstalled for FLUSH_CYCLES bubbles, feed still held off
module proxy_shift_scheduler #(
  parameter int NUM_ROWS     = 4,
  parameter int MAX_FAULTS   = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef PROXY_SHIFT_STATS_EN
  output logic [15:0] stall_cycles,
  output logic [7:0]  reconfig_count,
`endif
  proxy_shift_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    LOAD   = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t              st;
  logic [NUM_ROWS-1:0] pending;
  logic [NUM_ROWS-1:0] shift_en_q;
  logic [NUM_ROWS-1:0] prefix_or;
  logic [CNT_W-1:0]    settle_cnt;
  logic                cfg_ack_q;
  logic                cfg_err_q;
  logic                mask_ok;

  // Every row at or above the lowest faulty row shifts toward its proxy.
  always_comb begin
    logic acc;
    acc       = 1'b0;
    prefix_or = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      acc          = acc | pending[r];
      prefix_or[r] = acc;
    end
  end

  assign mask_ok = ($countones(pending) <= MAX_FAULTS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= RUN;
      pending    <= '0;
      shift_en_q <= '0;
      settle_cnt <= '0;
      cfg_ack_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_ack_q <= 1'b0;
      case (st)
        RUN: begin
          if (bus.cfg_req) begin
            pending <= bus.fault_map;
            st      <= HOLD;
          end
        end
        HOLD: st <= LOAD;
        LOAD: begin
          if (mask_ok) begin
            shift_en_q <= prefix_or;
            cfg_err_q  <= 1'b0;
          end else begin
            cfg_err_q  <= 1'b1;
          end
          settle_cnt <= CNT_W'(FLUSH_CYCLES - 1);
          st         <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            st        <= RUN;
            cfg_ack_q <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: st <= RUN;
      endcase
    end
  end

  assign bus.state      = st;
  assign bus.shift_en   = shift_en_q;
  assign bus.cfg_ack    = cfg_ack_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.feed_ready = (st == RUN);
  assign bus.busy       = (st != RUN);
  assign bus.stall      = (st == RUN) ? ~bus.feed_valid : (st == HOLD || st == LOAD);

`ifdef PROXY_SHIFT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles   <= '0;
      reconfig_count <= '0;
    end else begin
      if (bus.stall && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (cfg_ack_q)
        reconfig_count <= reconfig_count + 8'd1;
    end
  end
`endif

endmodule
